// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer.
package stream_demux_pkg;

  // Bits needed to index n items, never less than one bit.
  function automatic int selw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One output register of the demux: holds a word until its consumer takes it.
module stream_demux_slot #(
  parameter int WIDTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             tvalid,
  input  logic             tready,
  output logic [WIDTH-1:0] dout
);

  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;

  // A load wins over a drain so a full slot can be refilled every cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      data_p0 <= din;
    end else if (tready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign tvalid = vld_p0;
  assign dout   = data_p0;

endmodule

// File: rtl/stream_demux.sv
// Round-robin demultiplexer: one input stream spread over NOUTPUTS streams,
// BURST consecutive words per output before moving on.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int NOUTPUTS = 2,
  parameter int WIDTH    = 16,
  parameter int BURST    = 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [WIDTH-1:0]              s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  output logic [NOUTPUTS*WIDTH-1:0]     m_tdata,
  output logic [NOUTPUTS-1:0]           m_tvalid,
  input  logic [NOUTPUTS-1:0]           m_tready,
  output logic [selw(NOUTPUTS)-1:0]     sel
);

  localparam int SELW = selw(NOUTPUTS);
  localparam int CW   = selw(BURST);
  localparam logic [SELW-1:0] SEL_LAST = SELW'(NOUTPUTS - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(BURST - 1);

  logic [CW-1:0]       cnt;
  logic                sel_vld;
  logic                sel_rdy;
  logic                accept;
  logic [NOUTPUTS-1:0] load;

  // Look up the handshake state of the currently selected output.
  always_comb begin
    sel_vld = 1'b0;
    sel_rdy = 1'b0;
    for (int i = 0; i < NOUTPUTS; i++) begin
      if (sel == SELW'(i)) begin
        sel_vld = m_tvalid[i];
        sel_rdy = m_tready[i];
      end
    end
  end

  // Input is accepted only when the selected slot is empty or draining now.
  assign s_tready = aresetn && (!sel_vld || sel_rdy);
  assign accept   = s_tvalid && s_tready;

  // Steer the accepted word into the selected slot only.
  always_comb begin
    load = '0;
    for (int i = 0; i < NOUTPUTS; i++) begin
      load[i] = accept && (sel == SELW'(i));
    end
  end

  for (genvar g = 0; g < NOUTPUTS; g++) begin : g_slot
    stream_demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .aclk    (aclk),
      .aresetn (aresetn),
      .load    (load[g]),
      .din     (s_tdata),
      .tvalid  (m_tvalid[g]),
      .tready  (m_tready[g]),
      .dout    (m_tdata[g*WIDTH +: WIDTH])
    );
  end

  // Burst position and output index move only on an accepted word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
      sel <= '0;
    end else if (accept) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: five instances with different NOUTPUTS/BURST share
// one clock and reset; a scoreboard predicts every output from the
// round-robin rule "word w goes to output (w / BURST) % NOUTPUTS".
module tb_stream_demux;

  localparam int NI = 5;
  localparam int NO[NI] = '{4, 3, 2, 1, 4};
  localparam int BU[NI] = '{1, 2, 1, 1, 3};

  typedef logic [15:0] word_t;

  logic  aclk = 1'b0;
  logic  aresetn = 1'b0;
  int    cyc = 0;

  word_t      sdata  [NI];
  logic       svalid [NI];
  logic [3:0] mrd    [NI];
  logic       sready [NI];
  logic [3:0] mv     [NI];
  word_t      md     [NI][4];
  int         selx   [NI];

  logic [63:0] a_md; logic [3:0] a_mv; logic [1:0] a_sel; logic a_rdy;
  logic [47:0] b_md; logic [2:0] b_mv; logic [1:0] b_sel; logic b_rdy;
  logic [31:0] c_md; logic [1:0] c_mv; logic [0:0] c_sel; logic c_rdy;
  logic [15:0] d_md; logic [0:0] d_mv; logic [0:0] d_sel; logic d_rdy;
  logic [63:0] e_md; logic [3:0] e_mv; logic [1:0] e_sel; logic e_rdy;

  int vectors = 0;
  int miscompares = 0;

  word_t expq [NI*4][$];
  int    wcnt [NI];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  stream_demux #(.NOUTPUTS(4), .WIDTH(16), .BURST(1)) u_a (
    .aclk(aclk), .aresetn(aresetn), .s_tdata(sdata[0]), .s_tvalid(svalid[0]),
    .s_tready(a_rdy), .m_tdata(a_md), .m_tvalid(a_mv), .m_tready(mrd[0]), .sel(a_sel));
  stream_demux #(.NOUTPUTS(3), .WIDTH(16), .BURST(2)) u_b (
    .aclk(aclk), .aresetn(aresetn), .s_tdata(sdata[1]), .s_tvalid(svalid[1]),
    .s_tready(b_rdy), .m_tdata(b_md), .m_tvalid(b_mv), .m_tready(mrd[1][2:0]), .sel(b_sel));
  stream_demux #(.NOUTPUTS(2), .WIDTH(16), .BURST(1)) u_c (
    .aclk(aclk), .aresetn(aresetn), .s_tdata(sdata[2]), .s_tvalid(svalid[2]),
    .s_tready(c_rdy), .m_tdata(c_md), .m_tvalid(c_mv), .m_tready(mrd[2][1:0]), .sel(c_sel));
  stream_demux #(.NOUTPUTS(1), .WIDTH(16), .BURST(1)) u_d (
    .aclk(aclk), .aresetn(aresetn), .s_tdata(sdata[3]), .s_tvalid(svalid[3]),
    .s_tready(d_rdy), .m_tdata(d_md), .m_tvalid(d_mv), .m_tready(mrd[3][0:0]), .sel(d_sel));
  stream_demux #(.NOUTPUTS(4), .WIDTH(16), .BURST(3)) u_e (
    .aclk(aclk), .aresetn(aresetn), .s_tdata(sdata[4]), .s_tvalid(svalid[4]),
    .s_tready(e_rdy), .m_tdata(e_md), .m_tvalid(e_mv), .m_tready(mrd[4]), .sel(e_sel));

  // Gather the differently sized instance outputs into uniform arrays.
  always_comb begin
    for (int k = 0; k < NI; k++) begin
      mv[k] = '0;
      selx[k] = 0;
      sready[k] = 1'b0;
      for (int i = 0; i < 4; i++) md[k][i] = '0;
    end
    for (int i = 0; i < 4; i++) md[0][i] = a_md[i*16 +: 16];
    for (int i = 0; i < 3; i++) md[1][i] = b_md[i*16 +: 16];
    for (int i = 0; i < 2; i++) md[2][i] = c_md[i*16 +: 16];
    md[3][0] = d_md;
    for (int i = 0; i < 4; i++) md[4][i] = e_md[i*16 +: 16];
    mv[0] = a_mv;        mv[1] = {1'b0, b_mv}; mv[2] = {2'b0, c_mv};
    mv[3] = {3'b0, d_mv}; mv[4] = e_mv;
    selx[0] = int'(a_sel); selx[1] = int'(b_sel); selx[2] = int'(c_sel);
    selx[3] = int'(d_sel); selx[4] = int'(e_sel);
    sready[0] = a_rdy; sready[1] = b_rdy; sready[2] = c_rdy;
    sready[3] = d_rdy; sready[4] = e_rdy;
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Scoreboard: predicts the next clock edge from the model state, checks
  // the DUT outputs against it, then applies that edge to the model.
  always @(negedge aclk) begin : monitor
    int  e;
    bit  erdy;
    bit  ne;
    if (!aresetn) begin
      for (int k = 0; k < NI; k++) begin
        wcnt[k] = 0;
        for (int i = 0; i < 4; i++) expq[k*4+i].delete();
        chk("rst_mvalid", k, 32'(mv[k]), 32'd0);
        chk("rst_sel", k, selx[k], 32'd0);
        chk("rst_sready", k, 32'(sready[k]), 32'd0);
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        e    = (wcnt[k] / BU[k]) % NO[k];
        erdy = (expq[k*4+e].size() == 0) || mrd[k][e];
        chk("sel", k, selx[k], e);
        chk("s_tready", k, 32'(sready[k]), 32'(erdy));
        for (int i = 0; i < NO[k]; i++) begin
          ne = expq[k*4+i].size() != 0;
          chk("m_tvalid", k, 32'(mv[k][i]), 32'(ne));
          if (ne) begin
            chk("m_tdata", k, 32'(md[k][i]), 32'(expq[k*4+i][0]));
            if (mrd[k][i]) void'(expq[k*4+i].pop_front());
          end
        end
        if (svalid[k] && erdy) begin
          expq[k*4+e].push_back(sdata[k]);
          wcnt[k]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Offer one word on instance k and wait (bounded) for it to be taken.
  task automatic send(input int k, input word_t d);
    bit done;
    done = 1'b0;
    svalid[k] = 1'b1;
    sdata[k]  = d;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge aclk);
      if (sready[k]) done = 1'b1;
      tick();
    end
    svalid[k] = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout inst%0d: word %0h not accepted within 200 cycles", k, d);
    end
  endtask

  initial begin
    int c0;
    int accepted;
    int guard;
    for (int k = 0; k < NI; k++) begin
      svalid[k] = 1'b0;
      sdata[k]  = '0;
      mrd[k]    = 4'hF;
    end
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    tick();

    // Four outputs, burst 1, no backpressure.
    for (int v = 0; v < 8; v++) send(0, word_t'(v));
    repeat (3) tick();

    // Three outputs, burst 2.
    for (int v = 0; v < 12; v++) send(1, word_t'(v));
    repeat (3) tick();

    // Two outputs with output 1 stalled while full.
    mrd[2] = 4'b0001;
    for (int v = 0; v < 3; v++) send(2, word_t'(v));
    svalid[2] = 1'b1;
    sdata[2]  = 16'd3;
    repeat (6) tick();
    chk("stall_sel", 2, selx[2], 32'd1);
    chk("stall_sready", 2, 32'(sready[2]), 32'd0);
    chk("stall_data", 2, 32'(md[2][1]), 32'd1);
    mrd[2] = 4'hF;
    for (int v = 3; v < 8; v++) send(2, word_t'(v));
    repeat (3) tick();

    // Single output, back-to-back words.
    c0 = cyc;
    for (int v = 0; v < 16; v++) send(3, word_t'(16'h100 + v));
    chk("throughput_cycles", 3, cyc - c0, 32'd16);
    repeat (3) tick();

    // Reset in the middle of a burst.
    for (int v = 0; v < 5; v++) send(4, word_t'(16'h50 + v));
    aresetn = 1'b0;
    #1;
    chk("async_rst_mvalid", 4, 32'(mv[4]), 32'd0);
    chk("async_rst_sel", 4, selx[4], 32'd0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    tick();
    send(4, 16'd100);
    chk("post_rst_out0_valid", 4, 32'(mv[4][0]), 32'd1);
    chk("post_rst_out0_data", 4, 32'(md[4][0]), 32'd100);
    repeat (3) tick();

    // Randomized traffic and backpressure.
    accepted = 0;
    guard = 0;
    while (accepted < 10000 && guard < 60000) begin
      for (int k = 1; k < NI; k += 3) begin
        svalid[k] = $urandom_range(0, 3) != 0;
        sdata[k]  = word_t'($urandom);
        for (int i = 0; i < 4; i++) mrd[k][i] = $urandom_range(0, 3) != 0;
      end
      @(negedge aclk);
      if (svalid[4] && sready[4]) accepted++;
      tick();
      guard++;
    end
    if (accepted < 10000) begin
      vectors++;
      miscompares++;
      $display("FAIL random_timeout inst4: got %0d words expected 10000", accepted);
    end
    for (int k = 0; k < NI; k++) begin
      svalid[k] = 1'b0;
      mrd[k] = 4'hF;
    end
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter NOUTPUTS, default 2: number of output streams, legal range 1..64.
REQ-002 SHALL have parameter WIDTH, default 16: data bits per word.
REQ-003 SHALL have parameter BURST, default 1: consecutive words sent to one output before advancing, legal range 1..65536.
REQ-004 SHALL have port aclk, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port aresetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port s_tdata, input, WIDTH: input stream word.
REQ-007 SHALL have port s_tvalid, input, 1: input word present.
REQ-008 SHALL have port s_tready, output, 1: input word accepted when s_tvalid && s_tready.
REQ-009 SHALL have port m_tdata, output, NOUTPUTS*WIDTH: output i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port m_tvalid, output, NOUTPUTS: per-output valid.
REQ-011 SHALL have port m_tready, input, NOUTPUTS: per-output ready.
REQ-012 SHALL have port sel, output, SELW = max(1, clog2(NOUTPUTS)): index of the output receiving the next accepted word.

Function
REQ-013 SHALL be the inverse of the memstream mux: distribute one input stream across NOUTPUTS streams in round-robin order, sel = 0,1,..,NOUTPUTS-1,0,...
REQ-014 SHALL hold one output register (data + valid) per output; no other buffering.
REQ-015 SHALL drive s_tready = !m_tvalid[sel] || m_tready[sel], combinationally.
REQ-016 SHALL, on accept, load s_tdata into register sel and set m_tvalid[sel] the next cycle; input-to-output latency is exactly 1 cycle.
REQ-017 SHALL clear m_tvalid[i] on m_tvalid[i] && m_tready[i] unless register i is reloaded in the same cycle; simultaneous drain and load of one register keeps valid at 1 with new data, sustaining 1 word/cycle.
REQ-018 SHALL let non-selected outputs drain independently of input activity.
REQ-019 SHALL hold m_tdata[i] stable while m_tvalid[i] && !m_tready[i].
REQ-020 SHALL keep a burst counter cnt (width max(1, clog2(BURST))) that increments per accepted word; when cnt == BURST-1 on accept, cnt -> 0 and sel advances.
REQ-021 SHALL wrap sel from NOUTPUTS-1 to 0; with NOUTPUTS = 1, sel stays 0.
REQ-022 SHALL never reorder or skip: a stalled selected output blocks the whole input stream; sel and cnt change only on accept.
REQ-023 SHALL, with BURST = 1, advance sel on every accepted word.

Reset
REQ-024 SHALL, on aresetn low (asynchronously), clear all m_tvalid, m_tdata, sel and cnt to 0.
REQ-025 SHALL discard register contents and burst position on mid-operation reset; the first word after release goes to output 0.
REQ-026 SHALL hold s_tready low while aresetn is low.

Structure
REQ-027 SHALL place the SELW width computation, and no other constants, in the shared memstream package.
REQ-028 SHALL implement the per-output register as sub-module stream_demux_slot (ports: aclk, aresetn, load, din, tvalid, tready, dout), instantiated NOUTPUTS times.
REQ-029 SHALL keep sel/cnt control in the top module; no FSM beyond the two counters.

Verification
REQ-030 SHALL test NOUTPUTS=4, BURST=1, all m_tready=1: input 0..7 -> output 0 gets 0,4; output 1 gets 1,5; output 2 gets 2,6; output 3 gets 3,7; each 1 cycle after accept.
REQ-031 SHALL test NOUTPUTS=3, BURST=2: input 0..11 -> sel sequence 0,0,1,1,2,2,0,...; output 2 gets 4,5,10,11.
REQ-032 SHALL test NOUTPUTS=2, BURST=1: hold m_tready[1]=0 with output 1 full -> s_tready=0 when sel=1, sel frozen, m_tdata[1] stable; release -> stream resumes with no lost words.
REQ-033 SHALL test output 0 continuous accept+drain at NOUTPUTS=1 -> 1 word/cycle throughput, m_tvalid[0] held 1.
REQ-034 SHALL test asserting aresetn low mid-burst (NOUTPUTS=4, BURST=3, after 5 words) -> all m_tvalid=0, sel=0 immediately; next word appears on output 0.
REQ-035 SHALL test randomized s_tvalid/m_tready backpressure against a scoreboard model for 10000 words -> zero mismatches.
